trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised machine-mode trap controller, successor to the single-source interrupt controller. It arbitrates synchronous exceptions (illegal, ebreak, ecall), `mret`, the three standard M-mode interrupts, and `NUM_EXT` local interrupt lines that can be level- or edge-triggered. It requests a pipeline flush through a req/ack handshake, then issues the CSR write pulses and the PC redirect. It sits beside the CSR file and drives flush/redirect to every pipeline stage.

## Interface
- `XLEN`, 32: data and PC width.
- `NUM_EXT`, 8: local interrupt lines, 1..16; line i maps to cause 16+i.
- `EDGE_MASK`, `{NUM_EXT{1'b0}}`: bit i = 1 makes line i rising-edge triggered; 0 makes it level-triggered.
- `VECTORED_EN`, 1: 0 forces direct mode regardless of `mtvec` MODE.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `exc_i` in 4: {illegal, ebreak, ecall, mret}, from the mem stage.
- `exc_pc_i` in XLEN: PC of the instruction in the mem stage.
- `int_pc_i` in XLEN: PC of the oldest instruction not yet retired; this is the interrupt `mepc`.
- `instr_i` in 32: mem-stage instruction word, used as `tval` for illegal.
- `mstatus_mie_i` in 1: global interrupt enable.
- `mie_i` in 3, `mip_i` in 3: {MEI, MTI, MSI} enables and pendings.
- `ext_irq_i` in NUM_EXT: local interrupt lines, synchronous to `clk_i`.
- `ext_en_i` in NUM_EXT: per-line enables.
- `mtvec_i`, `mepc_i` in XLEN: CSR values.
- `flush_req_o` out 1, `flush_ack_i` in 1: pipeline flush handshake.
- `redirect_o` out 1, `new_pc_o` out XLEN: PC redirect.
- `cause_we_o` out 1, `cause_o` out XLEN: bit XLEN-1 = interrupt, bits [4:0] = code, other bits 0.
- `epc_we_o` out 1, `epc_o` out XLEN.
- `tval_we_o` out 1, `tval_o` out XLEN.
- `mie_clear_o` out 1, `mie_set_o` out 1: `mstatus.MIE` clear (trap) / set (mret).
- `ext_taken_o` out NUM_EXT: one-hot pulse naming the local line that was taken.

## Operation
- States: RUN, FLUSH (waiting for ack), TAKE, RET. Reset → RUN.
- Edge lines: a previous-value register per line. A rising edge sets a sticky pending bit. The bit clears in TAKE when that line is taken. Edges that arrive in any state are still latched.
- Level lines: pending equals `ext_irq_i[i]`.
- An interrupt is eligible when `mstatus_mie_i` is high and both enable and pending are set for that source.
- Priority in RUN, highest first: illegal, ebreak, ecall, mret, MEI(11), MSI(3), MTI(7), local lines (lowest index first).
- Exceptions record cause 2 / 3 / 11 with the interrupt bit 0.
- mret wins over a simultaneous interrupt. The interrupt stays pending and is re-evaluated in RUN after RET.
- On any event in RUN, register cause, interrupt flag, epc, tval, the selected line and a ret flag, then go to FLUSH. Inputs are not sampled again until RUN.
- epc: `exc_pc_i` for exceptions, `int_pc_i` for interrupts.
- tval: `instr_i` for illegal, `exc_pc_i` for ebreak, 0 for ecall and for interrupts.
- FLUSH: `flush_req_o` = 1. If `flush_ack_i` = 1, go to RET when the ret flag is set, otherwise to TAKE.
- TAKE (1 cycle): `redirect_o`, `cause_we_o`, `epc_we_o`, `tval_we_o` and `mie_clear_o` are 1; `ext_taken_o` is set if applicable. Then RUN.
- RET (1 cycle): `redirect_o` = 1, `new_pc_o` = `mepc_i`, `mie_set_o` = 1. Then RUN.
- Trap target: base = {`mtvec_i`[XLEN-1:2], 2'b00}.
  - If this is an interrupt, `VECTORED_EN` = 1 and `mtvec_i`[1:0] = 01: target = base + (code << 2), computed modulo 2^XLEN.
  - Otherwise target = base.
- Values on `mtvec_i` with MODE ≥ 2 are treated as direct mode.

## Timing
- Reset values:
  - All outputs 0, `new_pc_o` 0.
  - State RUN; captured registers and edge pending bits 0; previous-value registers 0.
- An event sampled in RUN at cycle t gives `flush_req_o` from t+1.
- With ack at t+1: TAKE or RET at t+2, so redirect latency is 2 cycles minimum.
- `flush_req_o` holds until the ack cycle. The ack is ignored outside FLUSH.
- All outputs are Moore, decoded from state plus captured registers. In RUN, outputs other than `new_pc_o` = 0 are 0.
- Reset asserted in any state returns to RUN next edge with all outputs 0. Partially latched events are discarded.

## Structure
- Package `trap_pkg`:
  - state enum;
  - cause constants: CAUSE_ILLEGAL = 2, CAUSE_EBREAK = 3, CAUSE_MSI = 3, CAUSE_MTI = 7, CAUSE_MEI = 11, CAUSE_ECALL = 11, CAUSE_LOCAL_BASE = 16;
  - `exc_i` bit indices.
- Sub-module `irq_pending`:
  - edge detect, sticky pending, enable masking and fixed-priority encode;
  - outputs: valid, 5-bit code, one-hot line select.
- The top level holds the FSM, capture registers and target computation.

## Test plan
- Illegal with `instr_i` = 0xFFFFFFFF, `exc_pc_i` = 0x100, `mtvec_i` = 0x8001, ack 1 cycle after req → TAKE: cause 0x2, epc 0x100, tval 0xFFFFFFFF, `new_pc_o` 0x8000 (exceptions are never vectored).
- MTI with mie/mip set, `mstatus_mie_i` = 1, `mtvec_i` = 0x8001, `int_pc_i` = 0x200 → cause 0x80000007, `new_pc_o` 0x801C, `mie_clear_o` pulse.
- Edge line 2 (`EDGE_MASK` = 0x04) pulsed 1 cycle while `mstatus_mie_i` = 0, then MIE set 10 cycles later → trap cause 0x80000012, `ext_taken_o` = 0x04, pending cleared, no second trap.
- mret and MEI in the same cycle, `mepc_i` = 0x300 → RET: `new_pc_o` 0x300, `mie_set_o`. Once MIE is observed set, MEI is taken: cause 0x8000000B.
- Ack held low 5 cycles → `flush_req_o` high for exactly those cycles plus the ack cycle. Exactly one TAKE; no CSR writes before it.
- `rst_i` asserted during FLUSH → all outputs 0 immediately (async). After release, RUN with no redirect.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states,
// cause codes, bit positions of the exception and interrupt vectors.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TAKE  = 2'd2,
        ST_RET   = 2'd3
    } state_e;

    // Cause codes (5-bit code field of mcause)
    localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK     = 5'd3;
    localparam logic [4:0] CAUSE_MSI        = 5'd3;
    localparam logic [4:0] CAUSE_MTI        = 5'd7;
    localparam logic [4:0] CAUSE_MEI        = 5'd11;
    localparam logic [4:0] CAUSE_ECALL      = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

    // Bit positions in the {illegal, ebreak, ecall, mret} exception vector
    localparam int EXC_ILLEGAL = 3;
    localparam int EXC_EBREAK  = 2;
    localparam int EXC_ECALL   = 1;
    localparam int EXC_MRET    = 0;

    // Bit positions in the {MEI, MTI, MSI} enable/pending vectors
    localparam int IRQ_MEI = 2;
    localparam int IRQ_MTI = 1;
    localparam int IRQ_MSI = 0;

    // mtvec MODE 01 selects vectored interrupts; 00 and the reserved
    // encodings all fall back to direct mode.
    function automatic logic mode_is_vectored(input logic [1:0] mode);
        return (mode == 2'b01);
    endfunction

endpackage

// File: rtl/irq_pending.sv
// Interrupt pending logic: edge capture for edge-triggered local lines,
// enable masking and the fixed-priority choice MEI > MSI > MTI > local[0..].
module irq_pending
    import trap_pkg::*;
#(
    parameter int                   NUM_EXT   = 8,
    parameter logic [NUM_EXT-1:0]   EDGE_MASK = {NUM_EXT{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mstatus_mie,
    input  logic [2:0]          mie,
    input  logic [2:0]          mip,
    input  logic [NUM_EXT-1:0]  ext_irq,
    input  logic [NUM_EXT-1:0]  ext_en,
    input  logic [NUM_EXT-1:0]  clear,
    output logic                valid,
    output logic [4:0]          code,
    output logic [NUM_EXT-1:0]  line_sel
);

    logic [NUM_EXT-1:0] prev_r;
    logic [NUM_EXT-1:0] edge_pend_r;
    logic [NUM_EXT-1:0] pend_s;
    logic [NUM_EXT-1:0] local_s;
    logic               found_s;

    // Previous line values and sticky edge-pending bits; a fresh edge wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r      <= '0;
            edge_pend_r <= '0;
        end else begin
            prev_r      <= ext_irq;
            edge_pend_r <= EDGE_MASK & ((ext_irq & ~prev_r) | (edge_pend_r & ~clear));
        end
    end

    // Effective pending view per line: sticky bit for edge lines, raw level otherwise.
    always_comb begin
        pend_s  = (EDGE_MASK & edge_pend_r) | (~EDGE_MASK & ext_irq);
        local_s = pend_s & ext_en;
    end

    // Fixed-priority encode of eligible sources, gated by the global enable.
    always_comb begin
        valid    = 1'b0;
        code     = 5'd0;
        line_sel = '0;
        found_s  = 1'b0;
        if (!mstatus_mie) begin
            valid = 1'b0;
        end else if (mie[IRQ_MEI] && mip[IRQ_MEI]) begin
            valid = 1'b1;
            code  = CAUSE_MEI;
        end else if (mie[IRQ_MSI] && mip[IRQ_MSI]) begin
            valid = 1'b1;
            code  = CAUSE_MSI;
        end else if (mie[IRQ_MTI] && mip[IRQ_MTI]) begin
            valid = 1'b1;
            code  = CAUSE_MTI;
        end else begin
            for (int i = 0; i < NUM_EXT; i++) begin
                if (local_s[i] && !found_s) begin
                    found_s     = 1'b1;
                    valid       = 1'b1;
                    code        = CAUSE_LOCAL_BASE + 5'(i);
                    line_sel[i] = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, mret and interrupts,
// runs the flush handshake, then issues CSR write pulses and the PC redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int                 XLEN        = 32,
    parameter int                 NUM_EXT     = 8,
    parameter logic [NUM_EXT-1:0] EDGE_MASK   = {NUM_EXT{1'b0}},
    parameter bit                 VECTORED_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [3:0]          exc_i,
    input  logic [XLEN-1:0]     exc_pc_i,
    input  logic [XLEN-1:0]     int_pc_i,
    input  logic [31:0]         instr_i,
    input  logic                mstatus_mie_i,
    input  logic [2:0]          mie_i,
    input  logic [2:0]          mip_i,
    input  logic [NUM_EXT-1:0]  ext_irq_i,
    input  logic [NUM_EXT-1:0]  ext_en_i,
    input  logic [XLEN-1:0]     mtvec_i,
    input  logic [XLEN-1:0]     mepc_i,
    output logic                flush_req_o,
    input  logic                flush_ack_i,
    output logic                redirect_o,
    output logic [XLEN-1:0]     new_pc_o,
    output logic                cause_we_o,
    output logic [XLEN-1:0]     cause_o,
    output logic                epc_we_o,
    output logic [XLEN-1:0]     epc_o,
    output logic                tval_we_o,
    output logic [XLEN-1:0]     tval_o,
    output logic                mie_clear_o,
    output logic                mie_set_o,
    output logic [NUM_EXT-1:0]  ext_taken_o
);

    state_e             state_r;
    state_e             state_next_s;

    logic               cap_int_r;
    logic               cap_ret_r;
    logic [4:0]         cap_code_r;
    logic [XLEN-1:0]    cap_epc_r;
    logic [XLEN-1:0]    cap_tval_r;
    logic [NUM_EXT-1:0] cap_line_r;

    logic               sel_valid_s;
    logic               sel_int_s;
    logic               sel_ret_s;
    logic [4:0]         sel_code_s;
    logic [XLEN-1:0]    sel_epc_s;
    logic [XLEN-1:0]    sel_tval_s;
    logic [NUM_EXT-1:0] sel_line_s;

    logic               irq_valid_s;
    logic [4:0]         irq_code_s;
    logic [NUM_EXT-1:0] irq_line_s;
    logic [NUM_EXT-1:0] taken_s;

    logic [XLEN-1:0]    trap_base_s;
    logic [XLEN-1:0]    target_s;
    logic [XLEN-1:0]    cause_s;

    irq_pending #(
        .NUM_EXT   (NUM_EXT),
        .EDGE_MASK (EDGE_MASK)
    ) u_irq_pending (
        .clk         (clk_i),
        .rst         (rst_i),
        .mstatus_mie (mstatus_mie_i),
        .mie         (mie_i),
        .mip         (mip_i),
        .ext_irq     (ext_irq_i),
        .ext_en      (ext_en_i),
        .clear       (taken_s),
        .valid       (irq_valid_s),
        .code        (irq_code_s),
        .line_sel    (irq_line_s)
    );

    // Event selection in RUN priority order: exceptions, mret, then interrupts.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_int_s   = 1'b0;
        sel_ret_s   = 1'b0;
        sel_code_s  = 5'd0;
        sel_epc_s   = exc_pc_i;
        sel_tval_s  = '0;
        sel_line_s  = '0;
        if (exc_i[EXC_ILLEGAL]) begin
            sel_valid_s = 1'b1;
            sel_code_s  = CAUSE_ILLEGAL;
            sel_tval_s  = XLEN'(instr_i);
        end else if (exc_i[EXC_EBREAK]) begin
            sel_valid_s = 1'b1;
            sel_code_s  = CAUSE_EBREAK;
            sel_tval_s  = exc_pc_i;
        end else if (exc_i[EXC_ECALL]) begin
            sel_valid_s = 1'b1;
            sel_code_s  = CAUSE_ECALL;
        end else if (exc_i[EXC_MRET]) begin
            sel_valid_s = 1'b1;
            sel_ret_s   = 1'b1;
        end else if (irq_valid_s) begin
            sel_valid_s = 1'b1;
            sel_int_s   = 1'b1;
            sel_code_s  = irq_code_s;
            sel_epc_s   = int_pc_i;
            sel_line_s  = irq_line_s;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; the ack only matters while a flush is requested.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (sel_valid_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!flush_ack_i) begin
                    state_next_s = ST_FLUSH;
                end else if (cap_ret_r) begin
                    state_next_s = ST_RET;
                end else begin
                    state_next_s = ST_TAKE;
                end
            end
            ST_TAKE: state_next_s = ST_RUN;
            ST_RET:  state_next_s = ST_RUN;
            default: state_next_s = ST_RUN;
        endcase
    end

    // Capture the selected event once in RUN; held until the next RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_int_r  <= 1'b0;
            cap_ret_r  <= 1'b0;
            cap_code_r <= 5'd0;
            cap_epc_r  <= '0;
            cap_tval_r <= '0;
            cap_line_r <= '0;
        end else if ((state_r == ST_RUN) && sel_valid_s) begin
            cap_int_r  <= sel_int_s;
            cap_ret_r  <= sel_ret_s;
            cap_code_r <= sel_code_s;
            cap_epc_r  <= sel_epc_s;
            cap_tval_r <= sel_tval_s;
            cap_line_r <= sel_line_s;
        end else begin
            cap_int_r  <= cap_int_r;
            cap_ret_r  <= cap_ret_r;
            cap_code_r <= cap_code_r;
            cap_epc_r  <= cap_epc_r;
            cap_tval_r <= cap_tval_r;
            cap_line_r <= cap_line_r;
        end
    end

    // Local line actually taken this cycle; also clears its sticky pending bit.
    always_comb begin
        if ((state_r == ST_TAKE) && cap_int_r) begin
            taken_s = cap_line_r;
        end else begin
            taken_s = '0;
        end
    end

    // Trap target: exceptions always go to base, interrupts may be vectored.
    always_comb begin
        trap_base_s = {mtvec_i[XLEN-1:2], 2'b00};
        if (VECTORED_EN && cap_int_r && mode_is_vectored(mtvec_i[1:0])) begin
            target_s = trap_base_s + XLEN'({cap_code_r, 2'b00});
        end else begin
            target_s = trap_base_s;
        end
    end

    // mcause value: interrupt flag in the MSB, code in the low five bits.
    always_comb begin
        cause_s          = '0;
        cause_s[XLEN-1]  = cap_int_r;
        cause_s[4:0]     = cap_code_r;
    end

    // Moore output decode from the state and the captured event.
    always_comb begin
        flush_req_o = 1'b0;
        redirect_o  = 1'b0;
        new_pc_o    = '0;
        cause_we_o  = 1'b0;
        cause_o     = '0;
        epc_we_o    = 1'b0;
        epc_o       = '0;
        tval_we_o   = 1'b0;
        tval_o      = '0;
        mie_clear_o = 1'b0;
        mie_set_o   = 1'b0;
        ext_taken_o = '0;
        case (state_r)
            ST_RUN: begin
                flush_req_o = 1'b0;
            end
            ST_FLUSH: begin
                flush_req_o = 1'b1;
            end
            ST_TAKE: begin
                redirect_o  = 1'b1;
                new_pc_o    = target_s;
                cause_we_o  = 1'b1;
                cause_o     = cause_s;
                epc_we_o    = 1'b1;
                epc_o       = cap_epc_r;
                tval_we_o   = 1'b1;
                tval_o      = cap_tval_r;
                mie_clear_o = 1'b1;
                ext_taken_o = taken_s;
            end
            ST_RET: begin
                redirect_o  = 1'b1;
                new_pc_o    = mepc_i;
                mie_set_o   = 1'b1;
            end
            default: begin
                flush_req_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_trap_ctrl;

    localparam int         XLEN    = 32;
    localparam int         NUM_EXT = 8;
    localparam logic [7:0] EDGE_M  = 8'h04;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  exc_i = 4'd0;
    logic [31:0] exc_pc_i = 32'd0, int_pc_i = 32'd0, instr_i = 32'd0;
    logic        mstatus_mie_i = 1'b0;
    logic [2:0]  mie_i = 3'd0, mip_i = 3'd0;
    logic [7:0]  ext_irq_i = 8'd0, ext_en_i = 8'd0;
    logic [31:0] mtvec_i = 32'h8001, mepc_i = 32'h300;
    logic        flush_ack_i = 1'b0;
    logic        flush_req_o, redirect_o, cause_we_o, epc_we_o, tval_we_o;
    logic        mie_clear_o, mie_set_o;
    logic [31:0] new_pc_o, cause_o, epc_o, tval_o;
    logic [7:0]  ext_taken_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN(XLEN), .NUM_EXT(NUM_EXT), .EDGE_MASK(EDGE_M), .VECTORED_EN(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .exc_i(exc_i), .exc_pc_i(exc_pc_i),
        .int_pc_i(int_pc_i), .instr_i(instr_i), .mstatus_mie_i(mstatus_mie_i),
        .mie_i(mie_i), .mip_i(mip_i), .ext_irq_i(ext_irq_i), .ext_en_i(ext_en_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i), .flush_req_o(flush_req_o),
        .flush_ack_i(flush_ack_i), .redirect_o(redirect_o), .new_pc_o(new_pc_o),
        .cause_we_o(cause_we_o), .cause_o(cause_o), .epc_we_o(epc_we_o),
        .epc_o(epc_o), .tval_we_o(tval_we_o), .tval_o(tval_o),
        .mie_clear_o(mie_clear_o), .mie_set_o(mie_set_o), .ext_taken_o(ext_taken_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A pending trap record and a phase: 0 idle, 1 awaiting ack, 2 trap entry, 3 return.
    typedef struct packed {
        logic        valid;
        logic        is_int;
        logic        is_ret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] tval;
        logic        has_line;
        logic [3:0]  line;
    } rec_t;

    int          m_phase;
    rec_t        m_rec;
    logic [7:0]  m_prev, m_pend;

    function automatic rec_t pick_trap();
        rec_t r;
        int   irq_code[3] = '{11, 3, 7};
        int   irq_bit[3]  = '{2, 0, 1};
        r = '0;
        if (exc_i[3]) begin
            r.valid = 1'b1; r.code = 5'd2; r.epc = exc_pc_i; r.tval = instr_i;
        end else if (exc_i[2]) begin
            r.valid = 1'b1; r.code = 5'd3; r.epc = exc_pc_i; r.tval = exc_pc_i;
        end else if (exc_i[1]) begin
            r.valid = 1'b1; r.code = 5'd11; r.epc = exc_pc_i;
        end else if (exc_i[0]) begin
            r.valid = 1'b1; r.is_ret = 1'b1;
        end else if (mstatus_mie_i) begin
            for (int k = 0; k < 3; k++) begin
                if (!r.valid && mie_i[irq_bit[k]] && mip_i[irq_bit[k]]) begin
                    r.valid = 1'b1; r.is_int = 1'b1; r.code = 5'(irq_code[k]); r.epc = int_pc_i;
                end
            end
            for (int i = 0; i < NUM_EXT; i++) begin
                if (!r.valid && ext_en_i[i] && (EDGE_M[i] ? m_pend[i] : ext_irq_i[i])) begin
                    r.valid = 1'b1; r.is_int = 1'b1; r.code = 5'(16 + i); r.epc = int_pc_i;
                    r.has_line = 1'b1; r.line = 4'(i);
                end
            end
        end
        return r;
    endfunction

    // Model update on each clock edge, with asynchronous reset like the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_rec   <= '0;
            m_prev  <= 8'd0;
            m_pend  <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_EXT; i++) begin
                if (!EDGE_M[i])
                    m_pend[i] <= 1'b0;
                else if (ext_irq_i[i] && !m_prev[i])
                    m_pend[i] <= 1'b1;
                else if (m_phase == 2 && m_rec.is_int && m_rec.has_line && m_rec.line == 4'(i))
                    m_pend[i] <= 1'b0;
            end
            m_prev <= ext_irq_i;
            if (m_phase == 0) begin
                if (pick_trap().valid) begin
                    m_rec   <= pick_trap();
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (flush_ack_i) m_phase <= m_rec.is_ret ? 3 : 2;
            end else begin
                m_phase <= 0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [31:0] e_pc, e_cause, e_epc, e_tval, e_ext, base;
        logic        e_req, e_redir, e_we, e_set;
        base = mtvec_i & 32'hFFFF_FFFC;
        e_req = (m_phase == 1); e_redir = (m_phase >= 2);
        e_we  = (m_phase == 2); e_set = (m_phase == 3);
        e_pc = 32'd0; e_cause = 32'd0; e_epc = 32'd0; e_tval = 32'd0; e_ext = 32'd0;
        if (m_phase == 2) begin
            e_cause = (m_rec.is_int ? 32'h8000_0000 : 32'd0) + 32'(m_rec.code);
            e_epc   = m_rec.epc;
            e_tval  = m_rec.tval;
            e_pc    = (m_rec.is_int && mtvec_i[1:0] == 2'b01) ? base + 32'(m_rec.code) * 32'd4 : base;
            e_ext   = (m_rec.is_int && m_rec.has_line) ? (32'd1 << m_rec.line) : 32'd0;
        end else if (m_phase == 3) begin
            e_pc = mepc_i;
        end
        chk("m_flush_req", 32'(flush_req_o), 32'(e_req));
        chk("m_redirect",  32'(redirect_o),  32'(e_redir));
        chk("m_new_pc",    new_pc_o,         e_pc);
        chk("m_cause_we",  32'(cause_we_o),  32'(e_we));
        chk("m_cause",     cause_o,          e_cause);
        chk("m_epc_we",    32'(epc_we_o),    32'(e_we));
        chk("m_epc",       epc_o,            e_epc);
        chk("m_tval_we",   32'(tval_we_o),   32'(e_we));
        chk("m_tval",      tval_o,           e_tval);
        chk("m_mie_clear", 32'(mie_clear_o), 32'(e_we));
        chk("m_mie_set",   32'(mie_set_o),   32'(e_set));
        chk("m_ext_taken", 32'(ext_taken_o), e_ext);
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse_exc(input logic [3:0] e, input logic [31:0] pc, input logic [31:0] ins);
        @(negedge clk); #1;
        exc_i = e; exc_pc_i = pc; instr_i = ins;
        @(negedge clk); #1;
        exc_i = 4'd0;
    endtask

    // Wait for the flush request, hold the ack low for 'hold' more cycles, then ack.
    // Returns at the negedge where TAKE/RET outputs are visible.
    task automatic handshake(input int hold, output int req_cycles);
        bit ok = 1'b0;
        req_cycles = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (flush_req_o) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            chk("flush_req_timeout", 32'd0, 32'd1);
            return;
        end
        req_cycles = 1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (flush_req_o) req_cycles++;
        end
        #1 flush_ack_i = 1'b1;
        @(negedge clk);
        flush_ack_i = 1'b0;
    endtask

    task automatic check_take(input string tag, input logic [31:0] cause, input logic [31:0] epc,
                              input logic [31:0] tval, input logic [31:0] pc, input logic [31:0] ext);
        chk({tag, "_redirect"},  32'(redirect_o),  32'd1);
        chk({tag, "_cause_we"},  32'(cause_we_o),  32'd1);
        chk({tag, "_cause"},     cause_o,          cause);
        chk({tag, "_epc"},       epc_o,            epc);
        chk({tag, "_tval"},      tval_o,           tval);
        chk({tag, "_new_pc"},    new_pc_o,         pc);
        chk({tag, "_mie_clear"}, 32'(mie_clear_o), 32'd1);
        chk({tag, "_ext_taken"}, 32'(ext_taken_o), ext);
    endtask

    initial begin
        int rc;
        int cnt;
        repeat (3) @(negedge clk);
        chk("reset_flush_req", 32'(flush_req_o), 32'd0);
        chk("reset_new_pc",    new_pc_o,         32'd0);
        #1 rst = 1'b0;

        // illegal instruction, exception target never vectored
        pulse_exc(4'b1000, 32'h100, 32'hFFFF_FFFF);
        handshake(1, rc);
        check_take("illegal", 32'h2, 32'h100, 32'hFFFF_FFFF, 32'h8000, 32'h0);
        @(negedge clk);
        chk("illegal_after_redirect", 32'(redirect_o), 32'd0);

        // ebreak: tval is the PC
        pulse_exc(4'b0100, 32'h500, 32'h1234_5678);
        handshake(0, rc);
        check_take("ebreak", 32'h3, 32'h500, 32'h500, 32'h8000, 32'h0);

        // machine timer interrupt, vectored
        @(negedge clk); #1;
        mie_i = 3'b010; mip_i = 3'b010; mstatus_mie_i = 1'b1; int_pc_i = 32'h200;
        @(negedge clk); #1;
        mip_i = 3'b000; mstatus_mie_i = 1'b0;
        handshake(0, rc);
        check_take("mti", 32'h8000_0007, 32'h200, 32'h0, 32'h801C, 32'h0);

        // software interrupt with reserved MODE 2 -> direct
        @(negedge clk); #1;
        mtvec_i = 32'h9002; mie_i = 3'b001; mip_i = 3'b001; mstatus_mie_i = 1'b1;
        @(negedge clk); #1;
        mip_i = 3'b000; mstatus_mie_i = 1'b0;
        handshake(0, rc);
        check_take("msi_direct", 32'h8000_0003, 32'h200, 32'h0, 32'h9000, 32'h0);
        #1 mtvec_i = 32'h8001;

        // edge line 2 latched while globally disabled, taken once later
        @(negedge clk); #1;
        ext_en_i = 8'h04; ext_irq_i = 8'h04;
        @(negedge clk); #1;
        ext_irq_i = 8'h00;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (flush_req_o) cnt++; end
        chk("edge_masked_no_req", 32'(cnt), 32'd0);
        #1 mstatus_mie_i = 1'b1;
        handshake(1, rc);
        check_take("edge2", 32'h8000_0012, 32'h200, 32'h0, 32'h8048, 32'h04);
        cnt = 0;
        repeat (8) begin @(negedge clk); if (flush_req_o) cnt++; end
        chk("edge_no_second_trap", 32'(cnt), 32'd0);
        #1 mstatus_mie_i = 1'b0; ext_en_i = 8'h00;

        // mret beats a simultaneous MEI; MEI then taken after the return
        @(negedge clk); #1;
        mstatus_mie_i = 1'b1; mie_i = 3'b100; mip_i = 3'b100; mepc_i = 32'h300; exc_i = 4'b0001;
        @(negedge clk); #1;
        exc_i = 4'd0;
        handshake(0, rc);
        chk("mret_redirect", 32'(redirect_o), 32'd1);
        chk("mret_new_pc",   new_pc_o,        32'h300);
        chk("mret_mie_set",  32'(mie_set_o),  32'd1);
        chk("mret_cause_we", 32'(cause_we_o), 32'd0);
        handshake(0, rc);
        check_take("mei", 32'h8000_000B, 32'h200, 32'h0, 32'h802C, 32'h0);
        #1 mip_i = 3'b000; mstatus_mie_i = 1'b0; mie_i = 3'b000;

        // ecall with the ack held off 5 cycles
        pulse_exc(4'b0010, 32'h400, 32'h0);
        handshake(5, rc);
        chk("ack_hold_req_cycles", 32'(rc), 32'd6);
        check_take("ecall", 32'hB, 32'h400, 32'h0, 32'h8000, 32'h0);
        @(negedge clk);
        chk("ecall_single_take", 32'(cause_we_o), 32'd0);

        // ack outside FLUSH is ignored
        #1 flush_ack_i = 1'b1;
        @(negedge clk); #1 flush_ack_i = 1'b0;
        chk("stray_ack_redirect", 32'(redirect_o), 32'd0);

        // reset during FLUSH
        pulse_exc(4'b1000, 32'h600, 32'hDEAD_BEEF);
        chk("pre_reset_flush_req", 32'(flush_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_flush_req", 32'(flush_req_o), 32'd0);
        chk("async_reset_redirect",  32'(redirect_o),  32'd0);
        @(negedge clk); #1 rst = 1'b0;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (redirect_o || flush_req_o) cnt++; end
        chk("post_reset_idle", 32'(cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
